ras_checkpointed: RTL
=====================

// Module: ras_checkpointed
//
// PURPOSE
// Parametrised return address stack for the fetch predictor, successor to the fixed 8-entry RAS.
// Circular stack of return targets, with a configurable depth and target width.
// Fetch pushes on calls and pops on returns. It reads the predicted return target combinationally.
// Each prediction carries a (top index, count) checkpoint, so the backend can restore the stack on a mispredict.
//
// PARAMETERS
// RAS_ENTRIES     8      stack depth; power of 2, >= 2
// TARGET_WIDTH    31     stored target width (PC[31:1])
// INIT_TARGET     '0     reset value of every entry
// (derived) IDX_W = $clog2(RAS_ENTRIES); CNT_W = $clog2(RAS_ENTRIES+1)
//
// PORTS
// CLK              in   1             clock, all state on rising edge
// RST              in   1             async reset, active-high
// push_valid       in   1             call: push push_target
// push_target      in   TARGET_WIDTH  return address to push
// pop_valid        in   1             return: pop top entry
// ras_target       out  TARGET_WIDTH  entry at top (predicted return target)
// ras_valid        out  1             count != 0
// ras_index        out  IDX_W         current top pointer (checkpoint)
// ras_count        out  CNT_W         current occupancy (checkpoint)
// restore_valid    in   1             mispredict restore
// restore_index    in   IDX_W         checkpointed top pointer
// restore_count    in   CNT_W         checkpointed occupancy
//
// BEHAVIOUR
// - Reset: async, active-high. While RST is high: ptr=0, count=0, every entry=INIT_TARGET.
//   Outputs at reset: ras_target=INIT_TARGET, ras_valid=0, ras_index=0, ras_count=0.
// - Outputs are combinational from registered state: ras_target=entry[ptr], ras_index=ptr, ras_count=count.
//   Zero-cycle read; next-state updates become visible the cycle after the edge.
// - ptr arithmetic is modulo RAS_ENTRIES (natural IDX_W wrap).
// - Priority: restore_valid > push/pop. While restore_valid is high, push_valid and pop_valid are ignored.
// - restore: ptr<=restore_index; count<=min(restore_count, RAS_ENTRIES). Entries are untouched.
//   Overwritten entries are not recovered; this is an accepted loss.
// - push only: entry[ptr+1]<=push_target; ptr<=ptr+1; count<=min(count+1, RAS_ENTRIES).
//   At full, the push overwrites the oldest entry and count stays at RAS_ENTRIES.
// - pop only, count>0: ptr<=ptr-1; count<=count-1.
// - pop only, count==0 (underflow): no state change; ras_valid stays 0.
// - push+pop same cycle (tail call / coroutine): entry[ptr]<=push_target; ptr unchanged.
//   count<=max(count,1). The pop consumes the pre-edge ras_target.
// - Neither push nor pop: hold.
// - Entries are storage only and need no per-entry valid; occupancy comes solely from count.
//
// TESTING
// - LIFO: reset; push A=0x100,B=0x200,C=0x300 -> ras_target=0x300,count=3. Pop x3 -> returns 0x300,0x200,0x100.
//   After those pops: ras_valid=0, ras_index=0.
// - Overflow: N=8; push 0x1..0x9 -> count=8, ras_index=1 (ptr wrapped).
//   8 pops then return 0x9..0x2 -> ras_valid=0; the 9th pop changes nothing.
// - Push+pop: after push 0x40, assert push=0x50 and pop together -> pop sees 0x40.
//   Next cycle: ras_target=0x50, count=1, ptr unchanged.
//   Repeat the same push+pop from empty -> count becomes 1.
// - Restore: push 0x10 and capture (idx=1,cnt=1); push 0x20,0x30.
//   restore(1,1) with push_valid=1 in the same cycle -> ras_target=0x10, count=1, push ignored.
//   restore_count=15 on N=8 -> count saturates to 8.
// - Underflow: from reset, pop x2 -> ptr=0, count=0, ras_target=INIT_TARGET throughout.
// - Reset mid-operation: with count=5, assert RST asynchronously between edges.
//   Outputs go to 0 / INIT_TARGET without waiting for a clock edge.
//   After release, the first push lands at index 1.

Source files
------------

// File: rtl/ras_checkpointed.sv
// ras_checkpointed: circular return address stack with (top index, count) checkpoint restore
module ras_checkpointed #(
  parameter int RAS_ENTRIES = 8,
  parameter int TARGET_WIDTH = 31,
  parameter logic [TARGET_WIDTH-1:0] INIT_TARGET = '0,
  localparam int IDX_W = $clog2(RAS_ENTRIES),
  localparam int CNT_W = $clog2(RAS_ENTRIES + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push_valid,
  input  logic [TARGET_WIDTH-1:0] push_target,
  input  logic                    pop_valid,
  output logic [TARGET_WIDTH-1:0] ras_target,
  output logic                    ras_valid,
  output logic [IDX_W-1:0]        ras_index,
  output logic [CNT_W-1:0]        ras_count,
  input  logic                    restore_valid,
  input  logic [IDX_W-1:0]        restore_index,
  input  logic [CNT_W-1:0]        restore_count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_ENTRIES);
  logic [TARGET_WIDTH-1:0] entry [RAS_ENTRIES];
  logic [IDX_W-1:0] ptr, ptr_n, wr_idx;
  logic [CNT_W-1:0] count, count_n;
  logic do_push, do_pop, do_both;
  assign do_push = push_valid & ~pop_valid & ~restore_valid;
  assign do_pop = pop_valid & ~push_valid & ~restore_valid & (count != '0);
  assign do_both = push_valid & pop_valid & ~restore_valid;
  assign wr_idx = do_both ? ptr : ptr + IDX_W'(1);
  assign ras_target = entry[ptr];
  assign ras_valid = count != '0;
  assign ras_index = ptr;
  assign ras_count = count;
  // next pointer/occupancy: restore wins, underflowing pops hold, tail call keeps ptr
  always_comb begin
    ptr_n = restore_valid ? restore_index : do_push ? ptr + IDX_W'(1) : do_pop ? ptr - IDX_W'(1) : ptr;
    count_n = restore_valid ? (restore_count > FULL ? FULL : restore_count) :
              do_push ? (count == FULL ? FULL : count + CNT_W'(1)) :
              do_pop ? count - CNT_W'(1) :
              (do_both && count == '0) ? CNT_W'(1) : count;
  end
  // pointer and occupancy registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ptr <= '0;
      count <= '0;
    end else begin
      ptr <= ptr_n;
      count <= count_n;
    end
  // target storage; a full-stack push silently overwrites the oldest entry
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) entry[i] <= INIT_TARGET;
    end else if (do_push || do_both) begin
      entry[wr_idx] <= push_target;
    end
endmodule
